// File: rtl/clock_settings_controller_pkg.sv
// clock_ui_pkg: mode encodings, field indices, range limits and the wrap-step helper
// shared by the clock UI sequencer.
package clock_ui_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE  = 3'd0,
        MODE_TIME  = 3'd1,
        MODE_DATE  = 3'd2,
        MODE_ALARM = 3'd3,
        MODE_TIMER = 3'd4
    } mode_t;

    localparam logic [1:0] FLD_0 = 2'd0;
    localparam logic [1:0] FLD_1 = 2'd1;
    localparam logic [1:0] FLD_2 = 2'd2;

    localparam int HOUR_MAX    = 23;
    localparam int MIN_SEC_MAX = 59;
    localparam int MONTH_MAX   = 12;

    // Out-of-range values snap to the end the user is heading towards.
    function automatic logic [15:0] wrap_step(input logic [15:0] v, input logic [15:0] lo,
                                              input logic [15:0] hi, input logic up);
        return (v < lo || v > hi) ? (up ? lo : hi)
             : up ? ((v == hi) ? lo : v + 16'd1)
                  : ((v == lo) ? hi : v - 16'd1);
    endfunction

endpackage

// File: rtl/clock_settings_controller_if.sv
// clock_settings_controller_if: front-panel buttons, live time/date, edit buses,
// stored alarm and commit strobes between the UI sequencer and its neighbours.
interface clock_settings_controller_if;
    logic        btn_mode, btn_next, btn_inc, btn_dec, btn_cancel;
    logic [7:0]  cur_sec, cur_min, cur_hour, cur_day, cur_month;
    logic [15:0] cur_year;
    logic [7:0]  edit_sec, edit_min, edit_hour, edit_day, edit_month;
    logic [15:0] edit_year;
    logic [7:0]  alarm_time_sec, alarm_time_min, alarm_time_hour;
    logic        set_time, set_date, set_alarm, set_timer;
    logic [2:0]  mode;
    logic [1:0]  field;
    logic        edit_active;

    modport master (
        input  btn_mode, btn_next, btn_inc, btn_dec, btn_cancel,
        input  cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        output edit_sec, edit_min, edit_hour, edit_day, edit_month, edit_year,
        output alarm_time_sec, alarm_time_min, alarm_time_hour,
        output set_time, set_date, set_alarm, set_timer,
        output mode, field, edit_active
    );

    modport slave (
        output btn_mode, btn_next, btn_inc, btn_dec, btn_cancel,
        output cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        input  edit_sec, edit_min, edit_hour, edit_day, edit_month, edit_year,
        input  alarm_time_sec, alarm_time_min, alarm_time_hour,
        input  set_time, set_date, set_alarm, set_timer,
        input  mode, field, edit_active
    );
endinterface

// File: rtl/clock_settings_controller_month_length.sv
// month_length: days in a month for a given year, full Gregorian leap rule.
module month_length (
    input  logic [7:0]  month,
    input  logic [15:0] year,
    output logic [7:0]  days
);
    logic leap;

    always_comb begin
        leap = ((year % 16'd4 == 16'd0) && (year % 16'd100 != 16'd0)) || (year % 16'd400 == 16'd0);
        days = (month == 8'd2) ? (leap ? 8'd29 : 8'd28)
             : (month == 8'd4 || month == 8'd6 || month == 8'd9 || month == 8'd11) ? 8'd30
             : 8'd31;
    end
endmodule

// File: rtl/clock_settings_controller.sv
// clock_settings_controller: button-driven editor for time, date, alarm and timer
// values with field-by-field wrap editing, commit strobes, cancel and idle timeout.
module clock_settings_controller
    import clock_ui_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int YEAR_MIN       = 2000,
    parameter int YEAR_MAX       = 2099,
    parameter int TIMER_MAX_MIN  = 10
) (
    input logic                        clk,
    input logic                        reset,
    clock_settings_controller_if.master ui
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mode_t       state, state_n;
    logic [1:0]  field, field_n;
    logic        active;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]  e_hour, e_min, e_sec, e_day, e_month;
    logic [15:0] e_year;
    logic [7:0]  hour_p, min_p, sec_p, day_p, day_n, month_p;
    logic [15:0] year_p;
    logic [7:0]  a_hour, a_min, a_sec;
    logic        st_time, st_date, st_alarm, st_timer;
    logic [7:0]  len_cur, len_nxt;
    logic        idle, any_btn, timeout, act_mode, commit, step_en, up;
    logic        hms, tmr, dt;
    logic        sel_hour, sel_min, sel_sec, sel_year, sel_month, sel_day;
    logic [1:0]  last;
    logic [15:0] min_max;

    month_length u_len_cur (.month(e_month), .year(e_year), .days(len_cur));
    month_length u_len_nxt (.month(month_p), .year(year_p), .days(len_nxt));

    assign idle     = state == MODE_IDLE;
    assign any_btn  = ui.btn_mode | ui.btn_next | ui.btn_inc | ui.btn_dec | ui.btn_cancel;
    assign timeout  = !idle && !any_btn && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign act_mode = ui.btn_mode && (idle || !ui.btn_cancel);
    assign last     = (state == MODE_TIMER) ? FLD_1 : FLD_2;
    assign commit   = !idle && !ui.btn_cancel && !ui.btn_mode && ui.btn_next && field == last;
    assign step_en  = !idle && !ui.btn_cancel && !ui.btn_mode && !ui.btn_next && (ui.btn_inc ^ ui.btn_dec);
    assign up       = ui.btn_inc;
    assign cnt_n    = (idle || any_btn || timeout) ? '0 : cnt + CW'(1);

    assign hms       = state == MODE_TIME || state == MODE_ALARM;
    assign tmr       = state == MODE_TIMER;
    assign dt        = state == MODE_DATE;
    assign sel_hour  = hms && field == FLD_0;
    assign sel_min   = (hms && field == FLD_1) || (tmr && field == FLD_0);
    assign sel_sec   = (hms && field == FLD_2) || (tmr && field == FLD_1);
    assign sel_year  = dt && field == FLD_0;
    assign sel_month = dt && field == FLD_1;
    assign sel_day   = dt && field == FLD_2;
    assign min_max   = tmr ? 16'(TIMER_MAX_MIN) : 16'(MIN_SEC_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MODE_IDLE;
            field  <= FLD_0;
            active <= 1'b0;
        end else begin
            state  <= state_n;
            field  <= field_n;
            active <= state_n != MODE_IDLE;
        end
    end

    always_comb begin
        state_n = state;
        field_n = field;
        if (!idle && (ui.btn_cancel || timeout)) begin
            state_n = MODE_IDLE;
            field_n = FLD_0;
        end else if (ui.btn_mode) begin
            state_n = (state == MODE_TIMER) ? MODE_IDLE : mode_t'(3'(state) + 3'd1);
            field_n = FLD_0;
        end else if (!idle && ui.btn_next) begin
            state_n = (field == last) ? MODE_IDLE : state;
            field_n = (field == last) ? FLD_0 : field + 2'd1;
        end
    end

    // Edit-register next values: snapshot on mode entry, otherwise a wrap step.
    always_comb begin
        hour_p  = e_hour;
        min_p   = e_min;
        sec_p   = e_sec;
        day_p   = e_day;
        month_p = e_month;
        year_p  = e_year;
        if (act_mode) begin
            hour_p  = (state_n == MODE_TIME) ? ui.cur_hour : (state_n == MODE_ALARM) ? a_hour : e_hour;
            min_p   = (state_n == MODE_TIME) ? ui.cur_min : (state_n == MODE_ALARM) ? a_min
                    : (state_n == MODE_TIMER) ? 8'd0 : e_min;
            sec_p   = (state_n == MODE_TIME) ? ui.cur_sec : (state_n == MODE_ALARM) ? a_sec
                    : (state_n == MODE_TIMER) ? 8'd0 : e_sec;
            day_p   = (state_n == MODE_DATE) ? ui.cur_day : e_day;
            month_p = (state_n == MODE_DATE) ? ui.cur_month : e_month;
            year_p  = (state_n == MODE_DATE) ? ui.cur_year : e_year;
        end else if (step_en) begin
            hour_p  = sel_hour ? 8'(wrap_step(16'(e_hour), 16'd0, 16'(HOUR_MAX), up)) : e_hour;
            min_p   = sel_min ? 8'(wrap_step(16'(e_min), 16'd0, min_max, up)) : e_min;
            sec_p   = sel_sec ? 8'(wrap_step(16'(e_sec), 16'd0, 16'(MIN_SEC_MAX), up)) : e_sec;
            day_p   = sel_day ? 8'(wrap_step(16'(e_day), 16'd1, 16'(len_cur), up)) : e_day;
            month_p = sel_month ? 8'(wrap_step(16'(e_month), 16'd1, 16'(MONTH_MAX), up)) : e_month;
            year_p  = sel_year ? wrap_step(e_year, 16'(YEAR_MIN), 16'(YEAR_MAX), up) : e_year;
        end
    end

    assign day_n = ((month_p != e_month || year_p != e_year) && day_p > len_nxt) ? len_nxt : day_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            e_hour   <= '0;
            e_min    <= '0;
            e_sec    <= '0;
            e_day    <= '0;
            e_month  <= '0;
            e_year   <= '0;
            a_hour   <= '0;
            a_min    <= '0;
            a_sec    <= '0;
            st_time  <= 1'b0;
            st_date  <= 1'b0;
            st_alarm <= 1'b0;
            st_timer <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            e_hour   <= hour_p;
            e_min    <= min_p;
            e_sec    <= sec_p;
            e_day    <= day_n;
            e_month  <= month_p;
            e_year   <= year_p;
            st_time  <= commit && state == MODE_TIME;
            st_date  <= commit && state == MODE_DATE;
            st_alarm <= commit && state == MODE_ALARM;
            st_timer <= commit && state == MODE_TIMER;
            if (commit && state == MODE_ALARM) begin
                a_hour <= e_hour;
                a_min  <= e_min;
                a_sec  <= e_sec;
            end
        end
    end

    assign ui.edit_hour       = e_hour;
    assign ui.edit_min        = e_min;
    assign ui.edit_sec        = e_sec;
    assign ui.edit_day        = e_day;
    assign ui.edit_month      = e_month;
    assign ui.edit_year       = e_year;
    assign ui.alarm_time_hour = a_hour;
    assign ui.alarm_time_min  = a_min;
    assign ui.alarm_time_sec  = a_sec;
    assign ui.set_time        = st_time;
    assign ui.set_date        = st_date;
    assign ui.set_alarm       = st_alarm;
    assign ui.set_timer       = st_timer;
    assign ui.mode            = state;
    assign ui.field           = field;
    assign ui.edit_active     = active;
endmodule

// File: tb/tb_clock_settings_controller.sv
// tb_clock_settings_controller: directed scenarios with hand-computed expectations
// for the clock settings UI sequencer.
module tb_clock_settings_controller;
    localparam logic [4:0] M = 5'b00001, N = 5'b00010, I = 5'b00100, D = 5'b01000, C = 5'b10000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    clock_settings_controller_if ui ();

    clock_settings_controller dut (.clk(clk), .reset(rst_n), .ui(ui));

    always #5 clk = ~clk;

    task automatic press(input logic [4:0] b);
        @(negedge clk);
        {ui.btn_cancel, ui.btn_dec, ui.btn_inc, ui.btn_next, ui.btn_mode} = b;
        @(negedge clk);
        {ui.btn_cancel, ui.btn_dec, ui.btn_inc, ui.btn_next, ui.btn_mode} = '0;
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                           input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d);
        ui.cur_hour = h; ui.cur_min = mi; ui.cur_sec = s;
        ui.cur_year = y; ui.cur_month = mo; ui.cur_day = d;
    endtask

    task automatic test_reset();
        {ui.btn_cancel, ui.btn_dec, ui.btn_inc, ui.btn_next, ui.btn_mode} = '0;
        set_cur(8'd23, 8'd59, 8'd58, 16'd2024, 8'd2, 8'd1);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ui.mode !== 3'd0) begin n_fail++; $display("FAIL rst_mode got %0d want 0", ui.mode); end
        n_cmp++; if (ui.edit_active !== 1'b0) begin n_fail++; $display("FAIL rst_active got %b want 0", ui.edit_active); end
        n_cmp++; if ({ui.edit_hour, ui.edit_min, ui.edit_sec, ui.edit_day, ui.edit_month, ui.edit_year} !== 56'd0) begin
            n_fail++; $display("FAIL rst_edit got %0d:%0d:%0d want 0:0:0", ui.edit_hour, ui.edit_min, ui.edit_sec); end
        n_cmp++; if ({ui.set_time, ui.set_date, ui.set_alarm, ui.set_timer, ui.field} !== 6'd0) begin
            n_fail++; $display("FAIL rst_strobes got %b%b%b%b want 0000", ui.set_time, ui.set_date, ui.set_alarm, ui.set_timer); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ignore();
        press(I);
        press(N);
        n_cmp++; if (ui.mode !== 3'd0 || ui.edit_hour !== 8'd0) begin
            n_fail++; $display("FAIL idle_ignore got mode %0d hour %0d want 0 0", ui.mode, ui.edit_hour); end
    endtask

    task automatic test_time_edit();
        press(M);
        n_cmp++; if (ui.mode !== 3'd1 || ui.edit_active !== 1'b1) begin
            n_fail++; $display("FAIL time_enter got mode %0d active %b want 1 1", ui.mode, ui.edit_active); end
        n_cmp++; if ({ui.edit_hour, ui.edit_min, ui.edit_sec} !== {8'd23, 8'd59, 8'd58}) begin
            n_fail++; $display("FAIL time_snap got %0d:%0d:%0d want 23:59:58", ui.edit_hour, ui.edit_min, ui.edit_sec); end
        press(I);
        n_cmp++; if (ui.edit_hour !== 8'd0) begin n_fail++; $display("FAIL time_hour_wrap got %0d want 0", ui.edit_hour); end
        press(N);
        press(D);
        n_cmp++; if (ui.edit_min !== 8'd58 || ui.field !== 2'd1) begin
            n_fail++; $display("FAIL time_min_dec got %0d field %0d want 58 1", ui.edit_min, ui.field); end
        press(N);
        press(N);
        n_cmp++; if (ui.set_time !== 1'b1 || ui.mode !== 3'd0 || {ui.set_date, ui.set_alarm, ui.set_timer} !== 3'b000) begin
            n_fail++; $display("FAIL time_commit got set_time %b mode %0d want 1 0", ui.set_time, ui.mode); end
        n_cmp++; if ({ui.edit_hour, ui.edit_min, ui.edit_sec} !== {8'd0, 8'd58, 8'd58}) begin
            n_fail++; $display("FAIL time_hold got %0d:%0d:%0d want 0:58:58", ui.edit_hour, ui.edit_min, ui.edit_sec); end
        @(negedge clk);
        n_cmp++; if (ui.set_time !== 1'b0 || ui.mode !== 3'd0) begin
            n_fail++; $display("FAIL time_strobe_len got %b mode %0d want 0 0", ui.set_time, ui.mode); end
    endtask

    task automatic date_day_dec(input logic [15:0] y, input logic [7:0] want, input string tag);
        set_cur(8'd1, 8'd2, 8'd3, y, 8'd2, 8'd1);
        press(M);
        press(M);
        press(N);
        press(N);
        press(D);
        n_cmp++; if (ui.edit_day !== want || ui.mode !== 3'd2) begin
            n_fail++; $display("FAIL %s got day %0d mode %0d want %0d 2", tag, ui.edit_day, ui.mode, want); end
        press(C);
    endtask

    task automatic test_leap();
        date_day_dec(16'd2024, 8'd29, "leap_2024");
        date_day_dec(16'd2023, 8'd28, "leap_2023");
        date_day_dec(16'd2000, 8'd29, "leap_2000");
        date_day_dec(16'd2100, 8'd28, "leap_2100");
        n_cmp++; if (ui.mode !== 3'd0 || ui.set_date !== 1'b0) begin
            n_fail++; $display("FAIL date_cancel got mode %0d set_date %b want 0 0", ui.mode, ui.set_date); end
    endtask

    task automatic test_clamp();
        set_cur(8'd0, 8'd0, 8'd0, 16'd2023, 8'd3, 8'd31);
        press(M);
        press(M);
        press(N);
        press(I);
        n_cmp++; if (ui.edit_month !== 8'd4 || ui.edit_day !== 8'd30) begin
            n_fail++; $display("FAIL clamp_apr got month %0d day %0d want 4 30", ui.edit_month, ui.edit_day); end
        press(C);
        set_cur(8'd0, 8'd0, 8'd0, 16'd2099, 8'd2, 8'd28);
        press(M);
        press(M);
        press(I);
        n_cmp++; if (ui.edit_year !== 16'd2000 || ui.edit_day !== 8'd28) begin
            n_fail++; $display("FAIL year_wrap got year %0d day %0d want 2000 28", ui.edit_year, ui.edit_day); end
        press(D);
        n_cmp++; if (ui.edit_year !== 16'd2099) begin n_fail++; $display("FAIL year_wrap_dn got %0d want 2099", ui.edit_year); end
        press(N);
        press(N);
        press(N);
        n_cmp++; if (ui.set_date !== 1'b1 || ui.mode !== 3'd0) begin
            n_fail++; $display("FAIL date_commit got set_date %b mode %0d want 1 0", ui.set_date, ui.mode); end
    endtask

    task automatic test_timer();
        press(M); press(M); press(M); press(M);
        n_cmp++; if (ui.mode !== 3'd4 || ui.edit_min !== 8'd0 || ui.edit_sec !== 8'd0) begin
            n_fail++; $display("FAIL timer_enter got mode %0d %0d:%0d want 4 0:0", ui.mode, ui.edit_min, ui.edit_sec); end
        press(D);
        n_cmp++; if (ui.edit_min !== 8'd10) begin n_fail++; $display("FAIL timer_min_dec got %0d want 10", ui.edit_min); end
        press(I);
        n_cmp++; if (ui.edit_min !== 8'd0) begin n_fail++; $display("FAIL timer_min_inc got %0d want 0", ui.edit_min); end
        press(N);
        press(I);
        n_cmp++; if (ui.edit_sec !== 8'd1) begin n_fail++; $display("FAIL timer_sec got %0d want 1", ui.edit_sec); end
        press(N);
        n_cmp++; if (ui.set_timer !== 1'b1 || ui.set_time !== 1'b0 || ui.mode !== 3'd0) begin
            n_fail++; $display("FAIL timer_commit got set_timer %b mode %0d want 1 0", ui.set_timer, ui.mode); end
        n_cmp++; if (ui.edit_min !== 8'd0 || ui.edit_sec !== 8'd1) begin
            n_fail++; $display("FAIL timer_hold got %0d:%0d want 0:1", ui.edit_min, ui.edit_sec); end
        @(negedge clk);
        n_cmp++; if (ui.set_timer !== 1'b0) begin n_fail++; $display("FAIL timer_strobe_len got %b want 0", ui.set_timer); end
    endtask

    task automatic test_alarm_commit();
        press(M); press(M); press(M);
        n_cmp++; if (ui.mode !== 3'd3 || ui.edit_hour !== 8'd0) begin
            n_fail++; $display("FAIL alarm_enter got mode %0d hour %0d want 3 0", ui.mode, ui.edit_hour); end
        press(I);
        press(N);
        press(I);
        press(N);
        press(N);
        n_cmp++; if (ui.set_alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_strobe got %b want 1", ui.set_alarm); end
        n_cmp++; if ({ui.alarm_time_hour, ui.alarm_time_min, ui.alarm_time_sec} !== {8'd1, 8'd1, 8'd0}) begin
            n_fail++; $display("FAIL alarm_store got %0d:%0d:%0d want 1:1:0", ui.alarm_time_hour, ui.alarm_time_min, ui.alarm_time_sec); end
    endtask

    task automatic test_priority();
        set_cur(8'd10, 8'd20, 8'd30, 16'd2024, 8'd5, 8'd5);
        press(M);
        press(I | D);
        n_cmp++; if (ui.edit_hour !== 8'd10 || ui.mode !== 3'd1) begin
            n_fail++; $display("FAIL incdec_noop got hour %0d mode %0d want 10 1", ui.edit_hour, ui.mode); end
        press(M | N);
        n_cmp++; if (ui.mode !== 3'd2 || ui.field !== 2'd0) begin
            n_fail++; $display("FAIL mode_over_next got mode %0d field %0d want 2 0", ui.mode, ui.field); end
        press(C | M);
        n_cmp++; if (ui.mode !== 3'd0) begin n_fail++; $display("FAIL cancel_over_mode got %0d want 0", ui.mode); end
    endtask

    task automatic test_timeout_cancel();
        bit saw = 1'b0;
        press(M); press(M); press(M);
        n_cmp++; if (ui.edit_hour !== 8'd1) begin n_fail++; $display("FAIL to_snap got %0d want 1", ui.edit_hour); end
        press(I);
        repeat (29) begin
            @(negedge clk);
            saw |= ui.set_alarm;
        end
        n_cmp++; if (ui.mode !== 3'd3) begin n_fail++; $display("FAIL to_early got mode %0d want 3", ui.mode); end
        @(negedge clk);
        saw |= ui.set_alarm;
        n_cmp++; if (ui.mode !== 3'd0 || ui.edit_active !== 1'b0) begin
            n_fail++; $display("FAIL to_expire got mode %0d want 0", ui.mode); end
        @(negedge clk);
        saw |= ui.set_alarm;
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL to_no_strobe got %b want 0", saw); end
        n_cmp++; if ({ui.alarm_time_hour, ui.alarm_time_min, ui.alarm_time_sec} !== {8'd1, 8'd1, 8'd0} || ui.edit_hour !== 8'd2) begin
            n_fail++; $display("FAIL to_alarm_kept got %0d:%0d edit %0d want 1:1 edit 2", ui.alarm_time_hour, ui.alarm_time_min, ui.edit_hour); end
        press(M);
        press(N);
        press(N);
        press(C | N);
        n_cmp++; if (ui.mode !== 3'd0 || ui.set_time !== 1'b0) begin
            n_fail++; $display("FAIL cancel_last got mode %0d set_time %b want 0 0", ui.mode, ui.set_time); end
        @(negedge clk);
        n_cmp++; if (ui.set_time !== 1'b0) begin n_fail++; $display("FAIL cancel_last_late got %b want 0", ui.set_time); end
    endtask

    task automatic test_reset_mid_edit();
        set_cur(8'd4, 8'd5, 8'd6, 16'd2030, 8'd7, 8'd8);
        press(M);
        press(M);
        press(N);
        press(N);
        n_cmp++; if (ui.mode !== 3'd2 || ui.field !== 2'd2 || ui.edit_year !== 16'd2030) begin
            n_fail++; $display("FAIL mid_setup got mode %0d field %0d year %0d want 2 2 2030", ui.mode, ui.field, ui.edit_year); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ui.mode !== 3'd0 || ui.field !== 2'd0 || ui.edit_active !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_ctl got mode %0d field %0d want 0 0", ui.mode, ui.field); end
        n_cmp++; if (ui.edit_year !== 16'd0 || ui.edit_day !== 8'd0 || ui.alarm_time_hour !== 8'd0) begin
            n_fail++; $display("FAIL mid_rst_data got year %0d day %0d alarm %0d want 0 0 0", ui.edit_year, ui.edit_day, ui.alarm_time_hour); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (ui.mode !== 3'd0) begin n_fail++; $display("FAIL mid_rst_stay got %0d want 0", ui.mode); end
        press(M);
        n_cmp++; if (ui.mode !== 3'd1 || ui.edit_hour !== 8'd4) begin
            n_fail++; $display("FAIL mid_rst_reenter got mode %0d hour %0d want 1 4", ui.mode, ui.edit_hour); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_time_edit();
        test_leap();
        test_clamp();
        test_timer();
        test_alarm_commit();
        test_priority();
        test_timeout_cancel();
        test_reset_mid_edit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
